id_stage_pipe: RTL
==================

# id_stage_pipe

Parametrised pipeline decode stage for the five-stage RISC-V core. It sits between the IF/ID register and EX. It contains:
- the architectural register file, with write-through bypass from WB;
- the team's `SCPU_ctrl_more` controller and `ImmGen` decoder;
- load-use hazard detection;
- the ID/EX pipeline register, with valid, stall-bubble and flush.

Compared with the plain decode stage, it adds configurable datapath width and register count (RV32I/RV32E), same-cycle WB bypass, and self-contained bubble insertion.

## Interface
Parameters:
- XLEN, 32, datapath width
- NREG, 32, number of architectural registers: 32 (RV32I) or 16 (RV32E)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- valid_in  input  1  inst_in/pc_in hold a real instruction
- inst_in  input  32  instruction from IF/ID
- pc_in  input  XLEN  PC from IF/ID
- wb_we  input  1  WB register write enable
- wb_addr  input  5  WB destination register
- wb_data  input  XLEN  WB write data
- flush  input  1  branch/jump taken in EX; squash the instruction entering EX
- stall_out  output  1  hold PC and IF/ID this cycle
- valid_EX  output  1  ID/EX holds a real instruction
- pc_EX  output  XLEN  registered PC
- Rs1_data_EX, Rs2_data_EX  output  XLEN  registered operands
- Rs1_addr_EX, Rs2_addr_EX, Rd_addr_EX  output  5  registered register addresses
- Imm_EX  output  XLEN  registered immediate, sign-extended to XLEN
- ALUSrc_B_EX, Branch_EX, BranchN_EX, RegWrite_EX, MemRW_EX  output  1  registered controls
- MemtoReg_EX, Jump_EX  output  2  registered controls
- ALU_Control_EX  output  4  registered ALU operation
- stall_cnt  output  32  load-use stall counter; present only with ID_PERF_CNT_EN

## Operation
Decode:
- Controller and ImmGen are driven combinationally from inst_in.
- rs1 = inst_in[19:15], rs2 = inst_in[24:20], rd = inst_in[11:7].
- ex_is_load is an internal ID/EX flag, set when opcode[6:2] == 5'b00000.

Register file:
- NREG x XLEN; x0 reads 0.
- Write at the clock edge when wb_we, wb_addr != 0 and wb_addr < NREG.
- Reading an address >= NREG returns 0.

Bypass:
- If wb_we, wb_addr == rsN, wb_addr != 0 and wb_addr < NREG, the read returns wb_data in the same cycle.

Hazard:
- hazard = valid_in & valid_EX & ex_is_load & Rd_addr_EX != 0 & ((Rs1_used & rs1 == Rd_addr_EX) | (Rs2_used & rs2 == Rd_addr_EX))
- stall_out = hazard & ~flush

ID/EX next-state priority:
1. flush: load a bubble.
2. hazard: load a bubble. The upstream instruction is held and re-presented next cycle.
3. ~valid_in: load a bubble.
4. Otherwise: load the decoded instruction and set valid_EX = 1.

Bubble definition: every ID/EX field is zero, including valid_EX, ex_is_load, RegWrite_EX, MemRW_EX, Branch_EX, BranchN_EX and Jump_EX.

Boundary behaviour:
- Load followed by a dependent instruction: exactly one stall cycle. The re-presented instruction finds a non-load (the bubble) in EX and proceeds.
- Load into x0 followed by a reader of x0: no stall.
- flush while hazard is true: no stall and a bubble is loaded. IF redirects in the same cycle.
- WB write and ID read of the same register in one cycle: ID sees the new value.

## Timing
- ID to EX latency: 1 cycle. Outputs change only on the clk rising edge or on reset.
- stall_out is combinational from inst_in, valid_in, flush and ID/EX state, and is valid in the same cycle.
- rst low: immediately clears all ID/EX outputs to 0 (valid_EX = 0), all registers x1..x(NREG-1) to 0, and stall_cnt to 0.
- Reset released mid-operation: the first edge after release captures normally. No partial state is retained.

## Configuration
- ID_PERF_CNT_EN defined:
  - stall_cnt increments by 1 on each clock edge where stall_out = 1.
  - It wraps from 0xFFFFFFFF to 0 and resets to 0.
- ID_PERF_CNT_EN undefined: the stall_cnt port and its counter do not exist. All other behaviour is identical.

## Test plan
- Reset then WB writes x5 = 0x1234: apply add x6,x5,x0 with a concurrent WB write of x5 = 0x1234 → next cycle Rs1_data_EX = 0x1234 (bypass), valid_EX = 1, RegWrite_EX = 1.
- lw x7,0(x1) followed by add x8,x7,x2 → stall_out = 1 for exactly one cycle; the cycle after the load, ID/EX holds a bubble (valid_EX = 0, RegWrite_EX = 0); the add then enters EX.
- lw x0,0(x1) followed by add x8,x0,x2 → stall_out stays 0 and there is no bubble.
- Hazard condition with flush = 1 → stall_out = 0; next cycle valid_EX = 0 and all controls = 0.
- NREG = 16: WB write to x20 = 0xFFFF followed by a read of x20 → Rs1_data_EX = 0; x4 is unaffected.
- ID_PERF_CNT_EN defined, three load-use pairs → stall_cnt = 3; assert rst low mid-sequence → stall_cnt = 0 and valid_EX = 0 immediately.

Source files
------------

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage between IF/ID and EX, with register file,
// WB bypass, load-use bubble and ID/EX register. Optional ID_PERF_CNT_EN.
module id_stage_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [31:0]     inst_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            stall_out,
    output logic            valid_EX,
    output logic [XLEN-1:0] pc_EX,
    output logic [XLEN-1:0] Rs1_data_EX,
    output logic [XLEN-1:0] Rs2_data_EX,
    output logic [4:0]      Rs1_addr_EX,
    output logic [4:0]      Rs2_addr_EX,
    output logic [4:0]      Rd_addr_EX,
    output logic [XLEN-1:0] Imm_EX,
    output logic            ALUSrc_B_EX,
    output logic            Branch_EX,
    output logic            BranchN_EX,
    output logic            RegWrite_EX,
    output logic            MemRW_EX,
    output logic [1:0]      MemtoReg_EX,
    output logic [1:0]      Jump_EX,
    output logic [3:0]      ALU_Control_EX
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_IMM   = 5'b00100;
    localparam logic [4:0] OP_AUIPC = 5'b00101;
    localparam logic [4:0] OP_STORE = 5'b01000;
    localparam logic [4:0] OP_R     = 5'b01100;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_BR    = 5'b11000;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_JAL   = 5'b11011;

    typedef struct packed {
        logic            valid;
        logic            is_load;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] imm;
        logic            alusrc_b;
        logic            branch;
        logic            branchn;
        logic            regwrite;
        logic            memrw;
        logic [1:0]      memtoreg;
        logic [1:0]      jump;
        logic [3:0]      alu_ctrl;
    } id_ex_t;

    logic [4:0] op;
    logic [2:0] f3;
    logic       f7b5;
    logic       legal;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign op    = inst_in[6:2];
    assign f3    = inst_in[14:12];
    assign f7b5  = inst_in[30];
    assign legal = inst_in[1:0] == 2'b11;
    assign rs1   = inst_in[19:15];
    assign rs2   = inst_in[24:20];
    assign rd    = inst_in[11:7];

    logic            c_alusrc_b;
    logic            c_branch;
    logic            c_branchn;
    logic            c_regwrite;
    logic            c_memrw;
    logic [1:0]      c_memtoreg;
    logic [1:0]      c_jump;
    logic [3:0]      c_alu;
    logic            rs1_used;
    logic            rs2_used;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_x;

    // Main controller: control lines and source-register usage
    always_comb begin
        c_alusrc_b = 1'b0;
        c_branch   = 1'b0;
        c_branchn  = 1'b0;
        c_regwrite = 1'b0;
        c_memrw    = 1'b0;
        c_memtoreg = 2'b00;
        c_jump     = 2'b00;
        c_alu      = 4'b0000;
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        unique case (1'b1)
            legal && op == OP_R: begin
                c_regwrite = 1'b1;
                c_alu      = {f7b5, f3};
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
            end
            legal && op == OP_IMM: begin
                c_regwrite = 1'b1;
                c_alusrc_b = 1'b1;
                c_alu      = {f7b5 & (f3 == 3'b101), f3};
                rs1_used   = 1'b1;
            end
            legal && op == OP_LOAD: begin
                c_regwrite = 1'b1;
                c_alusrc_b = 1'b1;
                c_memtoreg = 2'b01;
                rs1_used   = 1'b1;
            end
            legal && op == OP_STORE: begin
                c_memrw    = 1'b1;
                c_alusrc_b = 1'b1;
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
            end
            legal && op == OP_BR: begin
                c_branch   = ~f3[0];
                c_branchn  = f3[0];
                c_alu      = f3[2] ? {3'b001, f3[1]} : 4'b1000;
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
            end
            legal && op == OP_JAL: begin
                c_regwrite = 1'b1;
                c_memtoreg = 2'b10;
                c_jump     = 2'b01;
            end
            legal && op == OP_JALR: begin
                c_regwrite = 1'b1;
                c_alusrc_b = 1'b1;
                c_memtoreg = 2'b10;
                c_jump     = 2'b10;
                rs1_used   = 1'b1;
            end
            legal && op == OP_LUI: begin
                c_regwrite = 1'b1;
                c_alusrc_b = 1'b1;
                c_memtoreg = 2'b11;
            end
            legal && op == OP_AUIPC: begin
                c_regwrite = 1'b1;
                c_alusrc_b = 1'b1;
            end
            default: ;
        endcase
    end

    // Immediate generator, sign-extended to the datapath width
    always_comb begin
        imm32 = 32'd0;
        unique case (1'b1)
            op == OP_LOAD || op == OP_IMM || op == OP_JALR:
                imm32 = {{20{inst_in[31]}}, inst_in[31:20]};
            op == OP_STORE:
                imm32 = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
            op == OP_BR:
                imm32 = {{19{inst_in[31]}}, inst_in[31], inst_in[7],
                         inst_in[30:25], inst_in[11:8], 1'b0};
            op == OP_LUI || op == OP_AUIPC:
                imm32 = {inst_in[31:12], 12'd0};
            op == OP_JAL:
                imm32 = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12],
                         inst_in[20], inst_in[30:21], 1'b0};
            default: ;
        endcase
    end

    assign imm_x = XLEN'($signed(imm32));

    logic [XLEN-1:0] rf [1:NREG-1];
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    // Register file write port; x0 and out-of-range addresses never match
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREG; i++) rf[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++)
                if (wb_we && wb_addr == 5'(i)) rf[i] <= wb_data;
        end
    end

    // Read ports with same-cycle WB bypass; x0 and unmapped read as zero
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        for (int i = 1; i < NREG; i++) begin
            if (rs1 == 5'(i))
                rs1_val = (wb_we && wb_addr == rs1) ? wb_data : rf[i];
            if (rs2 == 5'(i))
                rs2_val = (wb_we && wb_addr == rs2) ? wb_data : rf[i];
        end
    end

    id_ex_t q;
    id_ex_t d;
    logic   hazard;
    logic   ex_load_hit;

    assign ex_load_hit = q.valid & q.is_load & (q.rd_addr != 5'd0);
    assign hazard = valid_in & ex_load_hit &
                    ((rs1_used & (rs1 == q.rd_addr)) |
                     (rs2_used & (rs2 == q.rd_addr)));
    assign stall_out = hazard & ~flush;

    // Next ID/EX contents: bubble on flush, hazard or empty slot
    always_comb begin
        d = '0;
        if (!flush && !hazard && valid_in) begin
            d.valid    = 1'b1;
            d.is_load  = op == OP_LOAD;
            d.pc       = pc_in;
            d.rs1_data = rs1_val;
            d.rs2_data = rs2_val;
            d.rs1_addr = rs1;
            d.rs2_addr = rs2;
            d.rd_addr  = rd;
            d.imm      = imm_x;
            d.alusrc_b = c_alusrc_b;
            d.branch   = c_branch;
            d.branchn  = c_branchn;
            d.regwrite = c_regwrite;
            d.memrw    = c_memrw;
            d.memtoreg = c_memtoreg;
            d.jump     = c_jump;
            d.alu_ctrl = c_alu;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else      q <= d;
    end

    assign valid_EX       = q.valid;
    assign pc_EX          = q.pc;
    assign Rs1_data_EX    = q.rs1_data;
    assign Rs2_data_EX    = q.rs2_data;
    assign Rs1_addr_EX    = q.rs1_addr;
    assign Rs2_addr_EX    = q.rs2_addr;
    assign Rd_addr_EX     = q.rd_addr;
    assign Imm_EX         = q.imm;
    assign ALUSrc_B_EX    = q.alusrc_b;
    assign Branch_EX      = q.branch;
    assign BranchN_EX     = q.branchn;
    assign RegWrite_EX    = q.regwrite;
    assign MemRW_EX       = q.memrw;
    assign MemtoReg_EX    = q.memtoreg;
    assign Jump_EX        = q.jump;
    assign ALU_Control_EX = q.alu_ctrl;

`ifdef ID_PERF_CNT_EN
    // Load-use stall counter, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           stall_cnt <= 32'd0;
        else if (stall_out) stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule
